// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory, control and IF/ID bundle for the fetch stage
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] fetch_count;
    logic        misaligned_err;

    // Fetch stage side: drives the memory request and the IF/ID register outputs.
    modport master (
        output imem_addr, imem_req,
        input  imem_rdata, imem_ready,
        input  stall, redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        output fetch_count, misaligned_err
    );

    // Environment side: instruction memory, hazard unit, branch resolution, decode.
    modport slave (
        input  imem_addr, imem_req,
        output imem_rdata, imem_ready,
        output stall, redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        input  fetch_count, misaligned_err
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction-fetch stage: PC, IF/ID register, fetch counter
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fetch_bus
);

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_fetch_count;
    logic        r_misaligned_err;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic        w_redirect_misaligned;
    logic        w_take_redirect;
    logic        w_hold;
    logic        w_bubble;
    logic        w_accept;

    assign w_pc_plus4            = r_pc + 32'd4;
    assign w_redirect_target     = {fetch_bus.redirect_pc[31:2], 2'b00};
    assign w_redirect_misaligned = |fetch_bus.redirect_pc[1:0];

    // Priority: redirect > stall > memory wait > accept.
    assign w_take_redirect = fetch_bus.redirect_valid;
    assign w_hold          = !w_take_redirect && fetch_bus.stall;
    assign w_bubble        = !w_take_redirect && !fetch_bus.stall && !fetch_bus.imem_ready;
    assign w_accept        = !w_take_redirect && !fetch_bus.stall && fetch_bus.imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_take_redirect) begin
            r_pc <= w_redirect_target;
        end else if (w_accept) begin
            r_pc <= w_pc_plus4;
        end
    end

    // The PC fields of IF/ID keep their last values through bubbles so decode
    // can still report the most recent fetched PC if it needs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd0;
        end else if (w_take_redirect || w_bubble) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
        end else if (w_accept) begin
            r_id_valid    <= 1'b1;
            r_id_instr    <= fetch_bus.imem_rdata;
            r_id_pc       <= r_pc;
            r_id_pc_plus4 <= w_pc_plus4;
        end else if (w_hold) begin
            r_id_valid    <= r_id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Sticky until reset; repeated misaligned redirects simply keep it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned_err <= 1'b0;
        end else if (w_take_redirect && w_redirect_misaligned) begin
            r_misaligned_err <= 1'b1;
        end
    end

    assign fetch_bus.imem_addr      = r_pc;
    assign fetch_bus.imem_req       = !rst;
    assign fetch_bus.id_valid       = r_id_valid;
    assign fetch_bus.id_instr       = r_id_instr;
    assign fetch_bus.id_pc          = r_id_pc;
    assign fetch_bus.id_pc_plus4    = r_id_pc_plus4;
    assign fetch_bus.fetch_count    = r_fetch_count;
    assign fetch_bus.misaligned_err = r_misaligned_err;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk;
    logic rst;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          step_id;
        logic [31:0] addr;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic [31:0] count;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    // Reference architectural state of the fetch stage.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_pc4;
    logic [31:0] m_count;
    logic        m_mis;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, id, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        if (addr == 32'h4) return 32'h00a0_0113;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One cycle of stimulus: drive inputs after the falling edge, advance the
    // reference to what the next rising edge must produce, and post that.
    task automatic step(input logic r, input logic st, input logic rv,
                        input logic [31:0] rpc, input logic rdy);
        logic [31:0] word;
        exp_t e;
        @(negedge clk);
        word = rdy ? mem_word(m_pc) : $urandom;
        rst                = r;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_ready     = rdy;
        bus.imem_rdata     = word;

        if (r) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR;
            m_id_pc = 32'd0; m_id_pc4 = 32'd0; m_count = 32'd0; m_mis = 1'b0;
        end else if (rv) begin
            m_pc = rpc & ~32'd3;
            m_valid = 1'b0; m_instr = NOP_INSTR;
            if (rpc % 4 != 0) m_mis = 1'b1;
        end else if (st) begin
            // everything holds
        end else if (!rdy) begin
            m_valid = 1'b0; m_instr = NOP_INSTR;
        end else begin
            m_valid  = 1'b1;
            m_instr  = word;
            m_id_pc  = m_pc;
            m_id_pc4 = m_pc + 32'd4;
            m_pc     = m_pc + 32'd4;
            m_count  = m_count + 32'd1;
        end

        step_no++;
        e.step_id = step_no;
        e.addr = m_pc;   e.req = !r;      e.valid = m_valid; e.instr = m_instr;
        e.id_pc = m_id_pc; e.id_pc4 = m_id_pc4; e.count = m_count; e.mis = m_mis;
        sb.push_back(e);
    endtask

    task automatic run(input logic st, input logic rdy);
        step(1'b0, st, 1'b0, 32'h0, rdy);
    endtask

    // Monitor: just after each rising edge, compare the DUT against the oldest posted result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("imem_addr",      e.step_id, bus.imem_addr,             e.addr);
                check("imem_req",       e.step_id, {31'd0, bus.imem_req},     {31'd0, e.req});
                check("id_valid",       e.step_id, {31'd0, bus.id_valid},     {31'd0, e.valid});
                check("id_instr",       e.step_id, bus.id_instr,              e.instr);
                check("id_pc",          e.step_id, bus.id_pc,                 e.id_pc);
                check("id_pc_plus4",    e.step_id, bus.id_pc_plus4,           e.id_pc4);
                check("fetch_count",    e.step_id, bus.fetch_count,           e.count);
                check("misaligned_err", e.step_id, {31'd0, bus.misaligned_err}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rpc;
        int sel;
        rst = 1'b1;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP_INSTR;
        m_id_pc = 32'd0; m_id_pc4 = 32'd0; m_count = 32'd0; m_mis = 1'b0;

        // Reset, then straight-line fetch of 0 and 4
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        // Stall for two cycles at PC 8, then release
        run(1'b1, 1'b1);
        run(1'b1, 1'b0);
        run(1'b0, 1'b1);
        // Reach 0x10, then three memory-wait cycles
        run(1'b0, 1'b1);
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b0);
        run(1'b0, 1'b1);
        // Redirect colliding with stall, then fetch at 0x40
        step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
        run(1'b0, 1'b1);
        // Misaligned redirect to the top of memory and wrap to zero
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run(1'b0, 1'b1);
        run(1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0101, 1'b1);
        run(1'b0, 1'b1);
        // Reset mid-stream while stalled with a valid instruction in IF/ID
        run(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: rpc = $urandom & 32'h0000_0FFC;
            endcase
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 rpc,
                 $urandom_range(0, 3) != 0);
        end
        run(1'b0, 1'b1);

        @(posedge clk);
        #2;
        check("scoreboard_drained", 0, sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
